// File: rtl/fpalu_pkg.sv
// Shared constants and types for the FP adder pre-alignment stage.
package fpalu_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 23;
  localparam int unsigned GRS_W  = 3;
  localparam int unsigned FP_W   = 1 + EXP_W + MAN_W;
  localparam int unsigned HSIG_W = 1 + MAN_W;           // hidden bit + mantissa
  localparam int unsigned SIG_W  = HSIG_W + GRS_W;      // aligned significand width

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [FP_W-1:0]  QNAN    = 32'h7FC00000;

  // binary32 field positions
  localparam int unsigned SIGN_BIT = FP_W - 1;
  localparam int unsigned EXP_MSB  = FP_W - 2;
  localparam int unsigned EXP_LSB  = MAN_W;
  localparam int unsigned MAN_MSB  = MAN_W - 1;

  typedef enum logic [1:0] {
    SPC_NONE = 2'b00,
    SPC_NAN  = 2'b01,
    SPC_INF  = 2'b10
  } spc_e;

  // Payload held between the unpack/order stage and the align stage
  typedef struct packed {
    logic              swap;
    logic              sign_l;
    logic              sign_s;
    logic [EXP_W-1:0]  exp;
    logic [EXP_W-1:0]  d;
    logic [HSIG_W-1:0] sig_l;
    logic [HSIG_W-1:0] sig_s;
    spc_e              spc;
    logic [FP_W-1:0]   spc_val;
  } s1_t;

endpackage

// File: rtl/fpalu_shift_sticky.sv
// Combinational right shift of a significand with sticky collection into bit 0.
//   i_sig   : significand with GRS bits (low bits zero on entry)
//   i_shamt : shift distance (exponent difference)
//   o_sig   : shifted significand, bit 0 ORed with every bit shifted out
module fpalu_shift_sticky
  import fpalu_pkg::*;
(
  input  logic [SIG_W-1:0] i_sig,
  input  logic [EXP_W-1:0] i_shamt,
  output logic [SIG_W-1:0] o_sig
);

  localparam int unsigned AMT_W = $clog2(SIG_W);

  logic              w_full;
  logic [AMT_W-1:0]  w_amt;
  logic [SIG_W-1:0]  w_shifted;
  logic [SIG_W-1:0]  w_mask;
  logic              w_sticky;

  assign w_full    = (i_shamt >= EXP_W'(SIG_W));
  assign w_amt     = i_shamt[AMT_W-1:0];
  assign w_shifted = i_sig >> w_amt;
  // Mask selects exactly the bits that fall off the bottom
  assign w_mask    = ~({SIG_W{1'b1}} << w_amt);
  assign w_sticky  = |(i_sig & w_mask);

  always_comb begin
    o_sig = {w_shifted[SIG_W-1:1], w_shifted[0] | w_sticky};
    if (w_full) begin
      o_sig = {{(SIG_W-1){1'b0}}, |i_sig};
    end
  end

endmodule

// File: rtl/fpalu_align.sv
// Two-stage pre-alignment for the binary32 adder: unpack/classify/order, then
// right-shift the smaller significand to the larger exponent keeping G/R/S.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand pair handshake (a_in, b_in)
//   out_valid/out_ready   : aligned result handshake
//   out_swap              : B was the larger magnitude
//   out_sign_a/out_sign_b : signs of larger / smaller operand
//   out_exp               : common biased exponent
//   out_sig_a/out_sig_b   : larger significand / aligned smaller significand
//   out_special(_val)     : NaN/inf bypass class and value
module fpalu_align
  import fpalu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  a_in,
  input  logic [FP_W-1:0]  b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_swap,
  output logic             out_sign_a,
  output logic             out_sign_b,
  output logic [EXP_W-1:0] out_exp,
  output logic [SIG_W-1:0] out_sig_a,
  output logic [SIG_W-1:0] out_sig_b,
  output logic [1:0]       out_special,
  output logic [FP_W-1:0]  out_special_val
);

  logic             w_a_sign, w_b_sign;
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MAN_W-1:0] w_a_man, w_b_man;
  logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic             w_swap;
  logic [EXP_W-1:0] w_l_exp, w_s_exp, w_l_eff, w_s_eff;
  logic [MAN_W-1:0] w_l_man, w_s_man;
  spc_e             w_spc;
  logic [FP_W-1:0]  w_spc_val;
  s1_t              w_s1_next;
  logic             w_s1_moves;
  logic [SIG_W-1:0] w_sig_b;

  logic             r_s1_valid;
  s1_t              r_s1;

  assign w_a_sign = a_in[SIGN_BIT];
  assign w_b_sign = b_in[SIGN_BIT];
  assign w_a_exp  = a_in[EXP_MSB:EXP_LSB];
  assign w_b_exp  = b_in[EXP_MSB:EXP_LSB];
  assign w_a_man  = a_in[MAN_MSB:0];
  assign w_b_man  = b_in[MAN_MSB:0];

  assign w_a_nan = (w_a_exp == EXP_MAX) && (w_a_man != '0);
  assign w_b_nan = (w_b_exp == EXP_MAX) && (w_b_man != '0);
  assign w_a_inf = (w_a_exp == EXP_MAX) && (w_a_man == '0);
  assign w_b_inf = (w_b_exp == EXP_MAX) && (w_b_man == '0);

  // Raw {exp,man} compare orders by magnitude; ties keep A as the larger
  assign w_swap  = ({w_b_exp, w_b_man} > {w_a_exp, w_a_man});
  assign w_l_exp = w_swap ? w_b_exp : w_a_exp;
  assign w_s_exp = w_swap ? w_a_exp : w_b_exp;
  assign w_l_man = w_swap ? w_b_man : w_a_man;
  assign w_s_man = w_swap ? w_a_man : w_b_man;

  // Denormals share the exponent of the smallest normal
  assign w_l_eff = (w_l_exp == '0) ? EXP_W'(1) : w_l_exp;
  assign w_s_eff = (w_s_exp == '0) ? EXP_W'(1) : w_s_exp;

  // Special-value classification
  always_comb begin
    w_spc     = SPC_NONE;
    w_spc_val = '0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a_sign != w_b_sign))) begin
      w_spc     = SPC_NAN;
      w_spc_val = QNAN;
    end else if (w_a_inf) begin
      w_spc     = SPC_INF;
      w_spc_val = a_in;
    end else if (w_b_inf) begin
      w_spc     = SPC_INF;
      w_spc_val = b_in;
    end
  end

  // Stage-1 payload
  always_comb begin
    w_s1_next         = '0;
    w_s1_next.swap    = w_swap;
    w_s1_next.sign_l  = w_swap ? w_b_sign : w_a_sign;
    w_s1_next.sign_s  = w_swap ? w_a_sign : w_b_sign;
    w_s1_next.exp     = w_l_eff;
    w_s1_next.d       = w_l_eff - w_s_eff;
    w_s1_next.sig_l   = {(w_l_exp != '0), w_l_man};
    w_s1_next.sig_s   = {(w_s_exp != '0), w_s_man};
    w_s1_next.spc     = w_spc;
    w_s1_next.spc_val = w_spc_val;
  end

  assign w_s1_moves = !out_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s1_moves;

  // Stage 1: unpack/order register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1 <= w_s1_next;
      end
    end
  end

  fpalu_shift_sticky u_shift (
    .i_sig   ({r_s1.sig_s, GRS_W'(0)}),
    .i_shamt (r_s1.d),
    .o_sig   (w_sig_b)
  );

  // Stage 2: aligned output register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_swap        <= 1'b0;
      out_sign_a      <= 1'b0;
      out_sign_b      <= 1'b0;
      out_exp         <= '0;
      out_sig_a       <= '0;
      out_sig_b       <= '0;
      out_special     <= '0;
      out_special_val <= '0;
    end else if (w_s1_moves) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_swap        <= r_s1.swap;
        out_sign_a      <= r_s1.sign_l;
        out_sign_b      <= r_s1.sign_s;
        out_exp         <= r_s1.exp;
        out_sig_a       <= {r_s1.sig_l, GRS_W'(0)};
        out_sig_b       <= w_sig_b;
        out_special     <= r_s1.spc;
        out_special_val <= r_s1.spc_val;
      end
    end
  end

endmodule

// File: tb/tb_fpalu_align.sv
// Randomized bench for fpalu_align with a magnitude-level reference model.
module tb_fpalu_align;

  typedef struct packed {
    logic        swap;
    logic        sa;
    logic        sb;
    logic [7:0]  exp;
    logic [26:0] siga;
    logic [26:0] sigb;
    logic [1:0]  spc;
    logic [31:0] sval;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in, b_in;
  logic        out_valid;
  logic        out_ready;
  logic        out_swap, out_sign_a, out_sign_b;
  logic [7:0]  out_exp;
  logic [26:0] out_sig_a, out_sig_b;
  logic [1:0]  out_special;
  logic [31:0] out_special_val;

  int   errors = 0;
  int   checks = 0;
  int   n_out  = 0;
  bit   rdy_rand = 1'b0;
  bit   have_hold = 1'b0;
  res_t hold_v;
  res_t q[$];

  fpalu_align dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_swap(out_swap), .out_sign_a(out_sign_a), .out_sign_b(out_sign_b),
    .out_exp(out_exp), .out_sig_a(out_sig_a), .out_sig_b(out_sig_b),
    .out_special(out_special), .out_special_val(out_special_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic res_t dut_res();
    res_t r;
    r = {out_swap, out_sign_a, out_sign_b, out_exp, out_sig_a, out_sig_b,
         out_special, out_special_val};
    return r;
  endfunction

  // Reference: order by |value|, align by integer division with remainder as sticky
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic [31:0] l, s;
    int el, es, d;
    longint unsigned ml, ms, qt, rem, div;
    bit an, bn, ai, bi;
    r = '0;
    r.swap = (b[30:0] > a[30:0]);
    l = r.swap ? b : a;
    s = r.swap ? a : b;
    r.sa = l[31];
    r.sb = s[31];
    el = (l[30:23] == 8'd0) ? 1 : int'(l[30:23]);
    es = (s[30:23] == 8'd0) ? 1 : int'(s[30:23]);
    ml = 64'(l[22:0]) + ((l[30:23] != 8'd0) ? 64'd8388608 : 64'd0);
    ms = 64'(s[22:0]) + ((s[30:23] != 8'd0) ? 64'd8388608 : 64'd0);
    r.exp  = 8'(el);
    r.siga = 27'(ml * 64'd8);
    d = el - es;
    if (d >= 27) begin
      qt  = 64'd0;
      rem = ms * 64'd8;
    end else begin
      div = 64'd1 << d;
      qt  = (ms * 64'd8) / div;
      rem = (ms * 64'd8) % div;
    end
    r.sigb = 27'(qt) | ((rem != 64'd0) ? 27'd1 : 27'd0);
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    if (an || bn || (ai && bi && (a[31] != b[31]))) begin
      r.spc = 2'b01; r.sval = 32'h7FC00000;
    end else if (ai) begin
      r.spc = 2'b10; r.sval = a;
    end else if (bi) begin
      r.spc = 2'b10; r.sval = b;
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0: v[30:0] = 31'd0;
      1: v[30:23] = 8'd0;
      2: v[30:0] = {8'hFF, 23'd0};
      3: begin v[30:23] = 8'hFF; if (v[22:0] == 23'd0) v[0] = 1'b1; end
      4, 5, 6, 7, 8: v[30:23] = 8'(120 + $urandom_range(0, 15));
      default: if (v[30:23] == 8'hFF) v[30:23] = 8'hFE;
    endcase
    return v;
  endfunction

  // Scoreboard/compare process, sampling on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        have_hold = 1'b0;
      end else begin
        if (have_hold) begin
          check("hold_valid", 128'(out_valid), 128'(1));
          check("hold_data", 128'(dut_res()), 128'(hold_v));
        end
        have_hold = 1'b0;
        if (out_valid) begin
          if (out_ready) begin
            if (q.size() == 0) begin
              check("spurious_out", 128'(1), 128'(0));
            end else begin
              check("out", 128'(dut_res()), 128'(q.pop_front()));
            end
            n_out++;
          end else begin
            hold_v    = dut_res();
            have_hold = 1'b1;
          end
        end
        if (in_valid && in_ready) q.push_back(model(a_in, b_in));
      end
    end
  end

  // Random backpressure driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) out_ready = ($urandom_range(0, 99) < 70);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_lit(input string name, input logic [31:0] a, input logic [31:0] b,
                            input res_t want);
    int n = 0;
    check({name, "_model"}, 128'(model(a, b)), 128'(want));
    send(a, b);
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check({name, "_lat"}, 128'(n), 128'(2));
    check(name, 128'(dut_res()), 128'(want));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 128'(q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_outs", 128'(dut_res()), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
  endtask

  initial begin
    int n0;
    logic [31:0] a, b;
    rst = 1'b1;
    in_valid = 1'b0;
    a_in = '0;
    b_in = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_pulse();

    out_ready = 1'b1;
    expect_lit("one_one",  32'h3F800000, 32'h3F800000, {3'b000, 8'h7F, 27'h4000000, 27'h4000000, 2'b00, 32'h0});
    expect_lit("one_three",32'h3F800000, 32'h40400000, {3'b100, 8'h80, 27'h6000000, 27'h2000000, 2'b00, 32'h0});
    expect_lit("d24",      32'h4B800000, 32'h3F800001, {3'b000, 8'h97, 27'h4000000, 27'h0000005, 2'b00, 32'h0});
    expect_lit("d25",      32'h4C000000, 32'h3FC00000, {3'b000, 8'h98, 27'h4000000, 27'h0000003, 2'b00, 32'h0});
    expect_lit("d31",      32'h4F000000, 32'h3F800000, {3'b000, 8'h9E, 27'h4000000, 27'h0000001, 2'b00, 32'h0});
    expect_lit("inf_opp",  32'h7F800000, 32'hFF800000, {3'b001, 8'hFF, 27'h4000000, 27'h4000000, 2'b01, 32'h7FC00000});
    expect_lit("inf_one",  32'h7F800000, 32'h3F800000, {3'b000, 8'hFF, 27'h4000000, 27'h0000001, 2'b10, 32'h7F800000});
    expect_lit("nan",      32'h3F800000, 32'h7FC00001, {3'b100, 8'hFF, 27'h6000008, 27'h0000001, 2'b01, 32'h7FC00000});
    expect_lit("zeros",    32'h00000000, 32'h80000000, {3'b001, 8'h01, 27'h0000000, 27'h0000000, 2'b00, 32'h0});
    expect_lit("denorm",   32'h00000001, 32'h00800000, {3'b100, 8'h01, 27'h4000000, 27'h0000008, 2'b00, 32'h0});

    // Backpressure: two pairs fill the pipe, then input stalls
    n0 = n_out;
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000);
    send(32'h40400000, 32'h3F000000);
    check("bp_in_ready", 128'(in_ready), 128'(0));
    check("bp_out_valid", 128'(out_valid), 128'(1));
    in_valid = 1'b1;
    a_in = 32'h41200000;
    b_in = 32'hC1200000;
    repeat (3) @(posedge clk);
    #1;
    check("bp_in_ready_hold", 128'(in_ready), 128'(0));
    out_ready = 1'b1;
    send(32'h41200000, 32'hC1200000);
    send(32'h42C80000, 32'h3DCCCCCD);
    wait_drain();
    check("bp_count", 128'(n_out - n0), 128'(4));

    // Reset with both stages full
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000);
    send(32'h40400000, 32'h3F000000);
    reset_pulse();
    out_ready = 1'b1;
    expect_lit("post_rst", 32'h3F800000, 32'h3F800000, {3'b000, 8'h7F, 27'h4000000, 27'h4000000, 2'b00, 32'h0});

    // Randomized traffic with random backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 500; i++) begin
      a = rnd_op();
      case ($urandom_range(0, 15))
        0: b = a;
        1: b = a ^ 32'h80000000;
        default: b = rnd_op();
      endcase
      send(a, b);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
